jk_drive_seq: RTL and testbench
===============================

JK_DRIVE_SEQ -- requirements
Module: jk_drive_seq

Interface
REQ-001 SHALL have parameter LEN_W, default 4, giving the width of the command repeat-count field.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have port cmd_valid, input, 1, command request.
REQ-005 SHALL have port cmd_op, input, 2, opcode: 00 hold, 01 reset, 10 set, 11 toggle.
REQ-006 SHALL have port cmd_len, input, LEN_W, drive length minus one.
REQ-007 SHALL have port q_fb, input, 1, Q of the downstream JK flip-flop.
REQ-008 SHALL have port mismatch_clr, input, 1, clears the sticky mismatch flag.
REQ-009 SHALL have port cmd_ready, output, 1, command accepted this cycle when high together with cmd_valid.
REQ-010 SHALL have port j, output, 1, registered J drive to the downstream flop.
REQ-011 SHALL have port k, output, 1, registered K drive to the downstream flop.
REQ-012 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-013 SHALL have port exp_q, output, 1, model of the downstream Q.
REQ-014 SHALL have port done, output, 1, one-cycle pulse at command completion.
REQ-015 SHALL have port mismatch, output, 1, sticky flag: q_fb differed from exp_q.

Function
REQ-016 SHALL implement FSM states IDLE, DRIVE and CHECK.
REQ-017 SHALL drive cmd_ready high only in IDLE; cmd_ready is a decode of the state.
REQ-018 In IDLE, cmd_valid high SHALL at that edge: latch cmd_op, load the counter with cmd_len, set {j,k}=cmd_op, and enter DRIVE.
REQ-019 In IDLE with cmd_valid low, the block SHALL hold j=k=0.
REQ-020 In DRIVE, {j,k} SHALL remain equal to the latched opcode for exactly cmd_len+1 cycles; cmd_len=0 gives 1 cycle and all-ones gives 2^LEN_W cycles.
REQ-021 At every edge that ends a DRIVE cycle, exp_q SHALL update: 00 unchanged, 01 becomes 0, 10 becomes 1, 11 inverts.
REQ-022 In DRIVE, the counter SHALL decrement each cycle; at counter==0 the next state SHALL be CHECK, and j,k SHALL return to 0 at that edge.
REQ-023 In CHECK, which lasts one cycle, if q_fb != exp_q then mismatch SHALL set at the end of the cycle; done SHALL be high during CHECK; the next state SHALL be IDLE.
REQ-024 cmd_valid SHALL be ignored outside IDLE; commands are never queued.
REQ-025 mismatch_clr SHALL clear mismatch; if set and clear occur in the same cycle, set SHALL win.
REQ-026 Counter arithmetic SHALL be unsigned LEN_W bits, with no wrap beyond the load value.

Reset
REQ-027 While rst_n is low, the block SHALL asynchronously force: state IDLE, j=0, k=0, exp_q=0, mismatch=0, done=0, busy=0, counter=0, and cmd_ready=1.
REQ-028 Reset asserted mid-DRIVE or mid-CHECK SHALL abort the command with no done pulse; exp_q=0 matches the downstream flop reset value.
REQ-029 On deassertion, the first command SHALL be accepted on the first rising edge with cmd_valid high.

Configuration
REQ-030 With macro JK_SEQ_CHECK_EN defined, CHECK and mismatch SHALL behave as specified above.
REQ-031 Without JK_SEQ_CHECK_EN, there SHALL be no CHECK state: the final DRIVE cycle SHALL go directly to IDLE with done high in that final DRIVE cycle, mismatch SHALL be tied 0, and q_fb and mismatch_clr SHALL be unused.

Verification
REQ-032 Reset, then cmd op=10, len=2 -> j=1,k=0 for 3 cycles, exp_q=1, done pulses once, mismatch=0 with a correct flop.
REQ-033 Op=11, len=3 starting from exp_q=0 -> 4 toggles, exp_q=0 at CHECK; a correct flop gives mismatch=0.
REQ-034 Force q_fb=0 during CHECK after op=10 -> mismatch=1 and held; mismatch_clr pulse -> 0; a clear coinciding with a new mismatch -> 1.
REQ-035 Hold cmd_valid high continuously with changing op -> only the ops present in IDLE cycles are executed; busy and cmd_ready are complementary.
REQ-036 Assert rst_n low during DRIVE of op=11, len=15 -> j=k=0 and exp_q=0 immediately, no done; the next command after release executes normally.

Source files
------------

// File: rtl/jk_drive_seq.sv
// jk_drive_seq: drives J/K of a downstream JK flip-flop for a commanded
// number of cycles and keeps a model of the flop's Q (exp_q).
// Optional feature macro: JK_SEQ_CHECK_EN adds a one-cycle CHECK state that
// compares q_fb against exp_q and raises a sticky mismatch flag. Without the
// macro the last DRIVE cycle returns straight to IDLE and mismatch is tied 0.
module jk_drive_seq #(
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd_op,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             q_fb,
  input  logic             mismatch_clr,
  output logic             cmd_ready,
  output logic             j,
  output logic             k,
  output logic             busy,
  output logic             exp_q,
  output logic             done,
  output logic             mismatch
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1
`ifdef JK_SEQ_CHECK_EN
    ,
    CHECK = 2'd2
`endif
  } state_t;

  localparam logic [LEN_W-1:0] CNT_ONE = LEN_W'(1);

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             j_q, j_d;
  logic             k_q, k_d;
  logic             exp_q_q, exp_q_d;
  logic             done_q, done_d;

  // Next-state logic: command acceptance, drive countdown and Q model update.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    j_d     = j_q;
    k_d     = k_q;
    exp_q_d = exp_q_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        j_d = 1'b0;
        k_d = 1'b0;
        if (cmd_valid) begin
          op_d       = cmd_op;
          cnt_d      = cmd_len;
          {j_d, k_d} = cmd_op;
          state_d    = DRIVE;
`ifndef JK_SEQ_CHECK_EN
          done_d     = (cmd_len == '0);
`endif
        end
      end
      DRIVE: begin
        case (op_q)
          2'b01:   exp_q_d = 1'b0;
          2'b10:   exp_q_d = 1'b1;
          2'b11:   exp_q_d = ~exp_q_q;
          default: exp_q_d = exp_q_q;
        endcase
        if (cnt_q == '0) begin
          j_d = 1'b0;
          k_d = 1'b0;
`ifdef JK_SEQ_CHECK_EN
          state_d = CHECK;
          done_d  = 1'b1;
`else
          state_d = IDLE;
`endif
        end else begin
          cnt_d = cnt_q - CNT_ONE;
`ifndef JK_SEQ_CHECK_EN
          done_d = (cnt_q == CNT_ONE);
`endif
        end
      end
`ifdef JK_SEQ_CHECK_EN
      CHECK: begin
        state_d = IDLE;
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered drive outputs, all cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= 2'b00;
      cnt_q   <= '0;
      j_q     <= 1'b0;
      k_q     <= 1'b0;
      exp_q_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      j_q     <= j_d;
      k_q     <= k_d;
      exp_q_q <= exp_q_d;
      done_q  <= done_d;
    end
  end

`ifdef JK_SEQ_CHECK_EN
  logic mismatch_q, mismatch_d;
  logic mismatch_set;

  // Sticky mismatch: a compare failure in CHECK takes priority over a clear.
  always_comb begin
    mismatch_set = (state_q == CHECK) && (q_fb != exp_q_q);
    mismatch_d   = mismatch_set | (mismatch_q & ~mismatch_clr);
  end

  // Mismatch flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mismatch_q <= 1'b0;
    end else begin
      mismatch_q <= mismatch_d;
    end
  end

  assign mismatch = mismatch_q;
`else
  logic unused_inputs;
  assign unused_inputs = q_fb ^ mismatch_clr;
  assign mismatch      = 1'b0;
`endif

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign j         = j_q;
  assign k         = k_q;
  assign exp_q     = exp_q_q;
  assign done      = done_q;

endmodule

// File: tb/tb_jk_drive_seq.sv
// Directed testbench for jk_drive_seq. Includes a behavioural model of the
// downstream JK flop to produce q_fb, with an override to inject bad feedback.
module tb_jk_drive_seq;

  localparam int LEN_W = 4;
`ifdef JK_SEQ_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic             cmd_valid;
  logic [1:0]       cmd_op;
  logic [LEN_W-1:0] cmd_len;
  logic             q_fb;
  logic             mismatch_clr;
  logic             cmd_ready;
  logic             j;
  logic             k;
  logic             busy;
  logic             exp_q;
  logic             done;
  logic             mismatch;

  logic flop_q;
  logic force_fb;
  logic force_val;

  int tests_run = 0;
  int tests_failed = 0;

  jk_drive_seq #(.LEN_W(LEN_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_op       (cmd_op),
    .cmd_len      (cmd_len),
    .q_fb         (q_fb),
    .mismatch_clr (mismatch_clr),
    .cmd_ready    (cmd_ready),
    .j            (j),
    .k            (k),
    .busy         (busy),
    .exp_q        (exp_q),
    .done         (done),
    .mismatch     (mismatch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream JK flip-flop that the sequencer is driving.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flop_q <= 1'b0;
    end else begin
      case ({j, k})
        2'b01:   flop_q <= 1'b0;
        2'b10:   flop_q <= 1'b1;
        2'b11:   flop_q <= ~flop_q;
        default: flop_q <= flop_q;
      endcase
    end
  end

  assign q_fb = force_fb ? force_val : flop_q;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] op, input logic [LEN_W-1:0] len);
    cmd_valid = v;
    cmd_op    = op;
    cmd_len   = len;
  endtask

  task automatic checkOutput(input string tag, input logic observed, input logic expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag, input logic ej, input logic ek, input logic eb,
                          input logic er, input logic ed, input logic ee, input logic em);
    checkOutput({tag, ".j"}, j, ej);
    checkOutput({tag, ".k"}, k, ek);
    checkOutput({tag, ".busy"}, busy, eb);
    checkOutput({tag, ".ready"}, cmd_ready, er);
    checkOutput({tag, ".done"}, done, ed);
    checkOutput({tag, ".exp_q"}, exp_q, ee);
    checkOutput({tag, ".mismatch"}, mismatch, em);
  endtask

  initial begin
    rst_n        = 1'b0;
    force_fb     = 1'b0;
    force_val    = 1'b0;
    mismatch_clr = 1'b0;
    applyStimulus(1'b0, 2'b00, 4'd0);
    #12;
    checkAll("reset", 0, 0, 0, 1, 0, 0, 0);
    rst_n = 1'b1;

    // Set command, three drive cycles
    applyStimulus(1'b1, 2'b10, 4'd2);
    tick();
    checkAll("set.c1", 1, 0, 1, 0, 0, 0, 0);
    applyStimulus(1'b0, 2'b00, 4'd0);
    tick();
    checkAll("set.c2", 1, 0, 1, 0, 0, 1, 0);
    tick();
    checkAll("set.c3", 1, 0, 1, 0, !CHK, 1, 0);
`ifdef JK_SEQ_CHECK_EN
    tick();
    checkAll("set.chk", 0, 0, 1, 0, 1, 1, 0);
`endif
    tick();
    checkAll("set.idle", 0, 0, 0, 1, 0, 1, 0);

    // Reset-op with len 0 brings exp_q back to 0
    applyStimulus(1'b1, 2'b01, 4'd0);
    tick();
    checkAll("rst.c1", 0, 1, 1, 0, !CHK, 1, 0);
    applyStimulus(1'b0, 2'b00, 4'd0);
`ifdef JK_SEQ_CHECK_EN
    tick();
    checkAll("rst.chk", 0, 0, 1, 0, 1, 0, 0);
`endif
    tick();
    checkAll("rst.idle", 0, 0, 0, 1, 0, 0, 0);

    // Toggle four times from 0
    applyStimulus(1'b1, 2'b11, 4'd3);
    tick();
    checkAll("tog.c1", 1, 1, 1, 0, 0, 0, 0);
    applyStimulus(1'b0, 2'b00, 4'd0);
    tick();
    checkAll("tog.c2", 1, 1, 1, 0, 0, 1, 0);
    tick();
    checkAll("tog.c3", 1, 1, 1, 0, 0, 0, 0);
    tick();
    checkAll("tog.c4", 1, 1, 1, 0, !CHK, 1, 0);
`ifdef JK_SEQ_CHECK_EN
    tick();
    checkAll("tog.chk", 0, 0, 1, 0, 1, 0, 0);
`endif
    tick();
    checkAll("tog.idle", 0, 0, 0, 1, 0, 0, 0);

    // Bad feedback during the check window
`ifdef JK_SEQ_CHECK_EN
    applyStimulus(1'b1, 2'b10, 4'd0);
    tick();
    checkAll("mm.drv", 1, 0, 1, 0, 0, 0, 0);
    applyStimulus(1'b0, 2'b00, 4'd0);
    tick();
    checkAll("mm.chk", 0, 0, 1, 0, 1, 1, 0);
    force_fb  = 1'b1;
    force_val = 1'b0;
    tick();
    checkAll("mm.set", 0, 0, 0, 1, 0, 1, 1);
    force_fb = 1'b0;
    tick();
    checkOutput("mm.held", mismatch, 1'b1);
    mismatch_clr = 1'b1;
    tick();
    checkOutput("mm.clr", mismatch, 1'b0);
    mismatch_clr = 1'b0;
    applyStimulus(1'b1, 2'b10, 4'd0);
    tick();
    applyStimulus(1'b0, 2'b00, 4'd0);
    mismatch_clr = 1'b1;
    tick();
    checkAll("mm2.chk", 0, 0, 1, 0, 1, 1, 0);
    force_fb = 1'b1;
    tick();
    checkOutput("mm2.setwins", mismatch, 1'b1);
    force_fb     = 1'b0;
    tick();
    checkOutput("mm2.clr", mismatch, 1'b0);
    mismatch_clr = 1'b0;
`else
    force_fb     = 1'b1;
    force_val    = 1'b0;
    mismatch_clr = 1'b1;
    applyStimulus(1'b1, 2'b10, 4'd0);
    tick();
    checkAll("mm.drv", 1, 0, 1, 0, 1, 0, 0);
    applyStimulus(1'b0, 2'b00, 4'd0);
    mismatch_clr = 1'b0;
    tick();
    checkAll("mm.idle", 0, 0, 0, 1, 0, 1, 0);
    force_fb = 1'b0;
`endif

    // cmd_valid held high with a changing op: only IDLE-cycle ops execute
    applyStimulus(1'b1, 2'b01, 4'd0);
    tick();
    checkAll("hold.s1", 0, 1, 1, 0, !CHK, 1, 0);
    applyStimulus(1'b1, 2'b10, 4'd0);
    tick();
`ifdef JK_SEQ_CHECK_EN
    checkAll("hold.s2", 0, 0, 1, 0, 1, 0, 0);
    applyStimulus(1'b1, 2'b00, 4'd0);
    tick();
`endif
    checkAll("hold.s2i", 0, 0, 0, 1, 0, 0, 0);
    applyStimulus(1'b1, 2'b11, 4'd0);
    tick();
    checkAll("hold.s3", 1, 1, 1, 0, !CHK, 0, 0);
    applyStimulus(1'b1, 2'b10, 4'd0);
    tick();
`ifdef JK_SEQ_CHECK_EN
    checkAll("hold.s4", 0, 0, 1, 0, 1, 1, 0);
    applyStimulus(1'b1, 2'b01, 4'd0);
    tick();
`endif
    checkAll("hold.s4i", 0, 0, 0, 1, 0, 1, 0);
    applyStimulus(1'b0, 2'b00, 4'd0);

    // Maximum length: 16 drive cycles
    applyStimulus(1'b1, 2'b10, 4'd15);
    tick();
    checkOutput("max.j1", j, 1'b1);
    applyStimulus(1'b0, 2'b00, 4'd0);
    for (int i = 2; i <= 16; i++) begin
      tick();
      checkOutput($sformatf("max.j%0d", i), j, 1'b1);
      checkOutput($sformatf("max.done%0d", i), done, (i == 16) && !CHK);
    end
`ifdef JK_SEQ_CHECK_EN
    tick();
    checkAll("max.chk", 0, 0, 1, 0, 1, 1, 0);
`endif
    tick();
    checkAll("max.idle", 0, 0, 0, 1, 0, 1, 0);

    // Reset in the middle of a long toggle command
    applyStimulus(1'b1, 2'b11, 4'd15);
    tick();
    applyStimulus(1'b0, 2'b00, 4'd0);
    tick();
    tick();
    checkAll("abort.pre", 1, 1, 1, 0, 0, 1, 0);
    rst_n = 1'b0;
    #1;
    checkAll("abort.rst", 0, 0, 0, 1, 0, 0, 0);
    tick();
    checkOutput("abort.nodone1", done, 1'b0);
    tick();
    checkOutput("abort.nodone2", done, 1'b0);
    rst_n = 1'b1;
    applyStimulus(1'b1, 2'b10, 4'd1);
    tick();
    checkAll("after.c1", 1, 0, 1, 0, 0, 0, 0);
    applyStimulus(1'b0, 2'b00, 4'd0);
    tick();
    checkAll("after.c2", 1, 0, 1, 0, !CHK, 1, 0);
`ifdef JK_SEQ_CHECK_EN
    tick();
    checkAll("after.chk", 0, 0, 1, 0, 1, 1, 0);
`endif
    tick();
    checkAll("after.idle", 0, 0, 0, 1, 0, 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
